// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer owning the 128-bit cipher state. With rk_ack held high, done follows start by NR+2 cycles, and every cycle without rk_ack adds one; ACK_TIMEOUT>0 ends a stalled key fetch with err.
// Optional abort input is compiled in when AES_ROUND_CTRL_ABORT_EN is defined.
module aes_round_ctrl #(
    parameter int NR          = 10,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         decrypt,
    input  logic [127:0] din,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         done,
    output logic [127:0] dout,
    output logic         err,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic         rk_ack,
    input  logic [127:0] rk,
    output logic [127:0] sb_in,
    output logic         sb_decrypt,
    input  logic [127:0] sb_out,
    output logic [127:0] mc_in,
    output logic         mc_inv,
    input  logic [127:0] mc_out
);

    typedef enum logic [1:0] {IDLE, KEY, FIN} fsm_e;

    localparam logic [3:0] NR_L    = 4'(NR);
    localparam bit         TO_EN   = (ACK_TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    fsm_e         fsm_q;
    logic [127:0] state_q;
    logic [127:0] state_d;
    logic [127:0] dout_q;
    logic [127:0] mc_in_w;
    logic         mode_q;
    logic         busy_q;
    logic         done_q;
    logic         err_q;
    logic         rk_req_q;
    logic [3:0]   rk_idx_q;
    logic [3:0]   step_q;
    logic [7:0]   to_cnt_q;
    logic         abort_w;
    logic         first_step;
    logic         last_step;
    logic         mid_step;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign first_step = (step_q == 4'd0);
    assign last_step  = (step_q == NR_L);
    assign mid_step   = (fsm_q == KEY) && !first_step && !last_step;

    // Decrypt adds the round key before InvMixColumns; encrypt adds it after MixColumns.
    always_comb begin
        mc_in_w = sb_out;
        if (mid_step && mode_q) begin
            mc_in_w = sb_out ^ rk;
        end
        state_d = state_q ^ rk;
        if (last_step) begin
            state_d = sb_out ^ rk;
        end else if (!first_step) begin
            state_d = mode_q ? mc_out : (mc_out ^ rk);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            dout_q   <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rk_req_q <= 1'b0;
            rk_idx_q <= '0;
            step_q   <= '0;
            to_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= din;
                        mode_q   <= decrypt;
                        busy_q   <= 1'b1;
                        rk_req_q <= 1'b1;
                        rk_idx_q <= decrypt ? NR_L : 4'd0;
                        step_q   <= '0;
                        to_cnt_q <= '0;
                        fsm_q    <= KEY;
                    end
                end
                KEY: begin
                    if (abort_w) begin
                        busy_q   <= 1'b0;
                        rk_req_q <= 1'b0;
                        to_cnt_q <= '0;
                        fsm_q    <= IDLE;
                    end else if (rk_ack) begin
                        state_q  <= state_d;
                        step_q   <= step_q + 4'd1;
                        to_cnt_q <= '0;
                        if (last_step) begin
                            rk_req_q <= 1'b0;
                            fsm_q    <= FIN;
                        end else begin
                            rk_idx_q <= mode_q ? (rk_idx_q - 4'd1) : (rk_idx_q + 4'd1);
                        end
                    end else if (TO_EN) begin
                        if (to_cnt_q == TO_LAST) begin
                            err_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            rk_req_q <= 1'b0;
                            to_cnt_q <= '0;
                            fsm_q    <= IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + 8'd1;
                        end
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    fsm_q  <= IDLE;
                    if (!abort_w) begin
                        dout_q <= state_q;
                        done_q <= 1'b1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign dout       = dout_q;
    assign err        = err_q;
    assign rk_req     = rk_req_q;
    assign rk_idx     = rk_idx_q;
    assign sb_in      = state_q;
    assign sb_decrypt = mode_q;
    assign mc_in      = mc_in_w;
    assign mc_inv     = mode_q;

endmodule
